augmented_matrix_loader: RTL and testbench

//  Upstream feeder for equotion_solver. Accepts the N x (N+1) augmented float32 matrix one

---
 rtl/matrix_ops_pkg.sv | 26 ++
 rtl/augmented_matrix_loader.sv | 139 +++++++++++++
 tb/tb_augmented_matrix_loader.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_ops_pkg.sv
// Shared definitions for the augmented-matrix loader and the equation solver:
// default sizes, element count, loader state encoding and the element index map.
package matrix_ops_pkg;

    localparam int unsigned MATRIX_SIZE_DEF = 3;
    localparam int unsigned DATA_WIDTH_DEF  = 32;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CMD  = 2'd1,
        WAIT = 2'd2
    } state_e;

    // Number of elements in an N x (N+1) augmented matrix.
    function automatic int unsigned nelem(input int unsigned n);
        return n * (n + 1);
    endfunction

    // Flat row-major index of element (row i, col j); column n is the RHS.
    function automatic int unsigned elem_index(input int unsigned i,
                                               input int unsigned j,
                                               input int unsigned n);
        return i * (n + 1) + j;
    endfunction

endpackage

// File: rtl/augmented_matrix_loader.sv
// Streams an N x (N+1) augmented matrix in word by word, packs it onto the
// solver's flat matrix bus, fires a start pulse and holds the data until done.
module augmented_matrix_loader
    import matrix_ops_pkg::*;
#(
    parameter int unsigned MATRIX_SIZE = MATRIX_SIZE_DEF,
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF
) (
    input  logic                                                    i_clk,
    input  logic                                                    i_rst_n,
    input  logic [DATA_WIDTH-1:0]                                   i_data,
    input  logic                                                    i_data_stb,
    input  logic                                                    i_data_last,
    output logic                                                    o_data_ack,
    output logic [DATA_WIDTH*MATRIX_SIZE*(MATRIX_SIZE+1)-1:0]       o_matrix,
    output logic                                                    o_calc_cmd,
    input  logic                                                    i_solver_done,
    output logic                                                    o_busy,
    output logic                                                    o_frame_err
);

    localparam int unsigned NELEM = nelem(MATRIX_SIZE);
    localparam int unsigned CNT_W = (NELEM > 1) ? $clog2(NELEM) : 1;
    localparam int unsigned MAT_W = DATA_WIDTH * NELEM;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [MAT_W-1:0]       matrix_q;
    logic                   calc_cmd_q;
    logic                   busy_q;
    logic                   frame_err_q;

    logic                   ack_c;
    logic                   xfer_c;
    logic                   last_slot_c;
    logic                   err_c;
    logic [NELEM-1:0]       slice_we_c;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: only a correctly terminated full frame leaves LOAD.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD: begin
                if (xfer_c && last_slot_c && i_data_last) begin
                    state_d = CMD;
                end
            end
            CMD: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (i_solver_done) begin
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // Handshake, word counter and framing-error decode.
    always_comb begin
        ack_c       = 1'b0;
        xfer_c      = 1'b0;
        last_slot_c = 1'b0;
        err_c       = 1'b0;
        cnt_d       = cnt_q;

        ack_c       = (state_q == LOAD);
        xfer_c      = i_data_stb && ack_c;
        last_slot_c = (cnt_q == CNT_W'(NELEM - 1));

        if (xfer_c) begin
            if (last_slot_c || i_data_last) begin
                // Either end of frame or a framing error; both restart at slot 0.
                cnt_d = '0;
                err_c = (last_slot_c != i_data_last);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // One write strobe per matrix slice, selected by the word counter.
    for (genvar k = 0; k < NELEM; k++) begin : g_slice_we
        assign slice_we_c[k] = xfer_c && (cnt_q == CNT_W'(k));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Matrix storage; writes only happen in LOAD, so it is frozen while busy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            matrix_q <= '0;
        end else begin
            for (int unsigned k = 0; k < NELEM; k++) begin
                if (slice_we_c[k]) begin
                    matrix_q[DATA_WIDTH*k +: DATA_WIDTH] <= i_data;
                end
            end
        end
    end

    // Registered status outputs track the state they describe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            calc_cmd_q  <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            calc_cmd_q  <= (state_d == CMD);
            busy_q      <= (state_d != LOAD);
            frame_err_q <= err_c;
        end
    end

    assign o_data_ack  = ack_c;
    assign o_matrix    = matrix_q;
    assign o_calc_cmd  = calc_cmd_q;
    assign o_busy      = busy_q;
    assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_augmented_matrix_loader.sv
// Scoreboard bench for augmented_matrix_loader: a frame-level model predicts
// commands and framing errors; a monitor compares them as the DUT emits them.
module tb_augmented_matrix_loader;

    localparam int unsigned N  = 3;
    localparam int unsigned DW = 32;
    localparam int unsigned NE = N * (N + 1);
    localparam int unsigned MW = DW * NE;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [DW-1:0]  data = '0;
    logic           data_stb = 1'b0;
    logic           data_last = 1'b0;
    logic           solver_done = 1'b0;
    logic           o_data_ack;
    logic [MW-1:0]  o_matrix;
    logic           o_calc_cmd;
    logic           o_busy;
    logic           o_frame_err;

    int checks = 0;
    int errors = 0;
    int force_delay = 0;
    int wait_cnt = 0;

    typedef struct {
        bit            is_err;
        logic [MW-1:0] mat;
    } exp_t;

    logic [DW-1:0] frame_q[$];
    exp_t          exp_q[$];
    logic [DW-1:0] words[NE];
    logic [MW-1:0] frozen = '0;

    always #5 clk = ~clk;

    augmented_matrix_loader #(
        .MATRIX_SIZE (N),
        .DATA_WIDTH  (DW)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_data        (data),
        .i_data_stb    (data_stb),
        .i_data_last   (data_last),
        .o_data_ack    (o_data_ack),
        .o_matrix      (o_matrix),
        .o_calc_cmd    (o_calc_cmd),
        .i_solver_done (solver_done),
        .o_busy        (o_busy),
        .o_frame_err   (o_frame_err)
    );

    function automatic void check(input bit ok, input string name,
                                  input logic [MW-1:0] act, input logic [MW-1:0] exp_v);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endfunction

    // Frame-level model: collect accepted words; a frame ends on last or when full.
    function automatic void model_accept(input logic [DW-1:0] d, input bit l);
        exp_t e;
        frame_q.push_back(d);
        if (l || frame_q.size() == NE) begin
            e.is_err = !(l && frame_q.size() == NE);
            e.mat    = '0;
            if (!e.is_err) begin
                foreach (frame_q[k]) e.mat[DW*k +: DW] = frame_q[k];
            end
            exp_q.push_back(e);
            frame_q.delete();
        end
    endfunction

    function automatic void fill_random();
        for (int k = 0; k < NE; k++) words[k] = $urandom;
    endfunction

    // Called at a negedge; returns at the negedge after the word transfers.
    task automatic drive_word(input logic [DW-1:0] d, input bit l, input int gap,
                              output int waited);
        waited = 0;
        if (gap > 0) begin
            data_stb = 1'b0;
            repeat (gap) begin
                data      = $urandom;
                data_last = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
        end
        data      = d;
        data_stb  = 1'b1;
        data_last = l;
        while (!o_data_ack) begin
            @(negedge clk);
            waited++;
            if (waited > 500) begin
                check(1'b0, "ack_timeout", MW'(0), MW'(1));
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $fatal(1, "ack never rose");
            end
        end
        model_accept(d, l);
        @(negedge clk);
    endtask

    // kind: 0 clean, 1 early last on word pos, 2 missing last, 3 partial (pos words, no end)
    task automatic send_frame(input int kind, input int pos, input int gmin, input int gmax,
                              output int first_wait);
        int n;
        int w;
        bit l;
        n = (kind == 1 || kind == 3) ? pos : NE;
        first_wait = 0;
        for (int k = 0; k < n; k++) begin
            l = (k == n - 1) && (kind == 0 || kind == 1);
            drive_word(words[k], l, int'($urandom_range(gmin, gmax)), w);
            if (k == 0) first_wait = w;
        end
        data_stb  = 1'b0;
        data_last = 1'b0;
        if (kind == 0) begin
            check(o_calc_cmd === 1'b1, "cmd_latency", MW'(o_calc_cmd), MW'(1));
        end else if (kind != 3) begin
            check(o_frame_err === 1'b1, "err_pulse", MW'(o_frame_err), MW'(1));
            check(o_calc_cmd === 1'b0, "no_cmd_on_err", MW'(o_calc_cmd), MW'(0));
        end
    endtask

    // Called at a negedge: async reset, immediate value check, release two cycles later.
    task automatic do_reset();
        #2;
        rst_n     = 1'b0;
        data_stb  = 1'b0;
        data_last = 1'b0;
        #1;
        check(o_data_ack === 1'b1, "rst_ack", MW'(o_data_ack), MW'(1));
        check(o_matrix === '0, "rst_matrix", o_matrix, MW'(0));
        check(o_calc_cmd === 1'b0, "rst_cmd", MW'(o_calc_cmd), MW'(0));
        check(o_busy === 1'b0, "rst_busy", MW'(o_busy), MW'(0));
        check(o_frame_err === 1'b0, "rst_err", MW'(o_frame_err), MW'(0));
        frame_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Solver stand-in: done after a delay per command, plus stray done pulses in LOAD.
    initial begin
        forever begin
            @(negedge clk);
            solver_done = 1'b0;
            if (!rst_n) begin
                wait_cnt = 0;
            end else if (wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0) solver_done = 1'b1;
            end else if (o_calc_cmd) begin
                wait_cnt = (force_delay > 0) ? force_delay : int'($urandom_range(1, 25));
            end else if (!o_busy && $urandom_range(0, 7) == 0) begin
                solver_done = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT reports a command or error.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check(o_data_ack === !o_busy, "ack_vs_busy", MW'(o_data_ack), MW'(!o_busy));
                if (o_calc_cmd || o_frame_err) begin
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_event", MW'({o_calc_cmd, o_frame_err}), MW'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check(o_frame_err === e.is_err, "event_err", MW'(o_frame_err), MW'(e.is_err));
                        check(o_calc_cmd === !e.is_err, "event_cmd", MW'(o_calc_cmd), MW'(!e.is_err));
                        if (!e.is_err) begin
                            check(o_matrix === e.mat, "cmd_matrix", o_matrix, e.mat);
                            frozen = e.mat;
                        end
                    end
                end else if (o_busy) begin
                    check(o_matrix === frozen, "matrix_frozen", o_matrix, frozen);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        check(1'b0, "global_timeout", MW'(0), MW'(1));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "simulation timeout");
    end

    initial begin
        int fw;
        int kind;
        logic [MW-1:0] m;

        // Reset values
        repeat (2) @(negedge clk);
        check(o_data_ack === 1'b1, "init_ack", MW'(o_data_ack), MW'(1));
        check(o_matrix === '0, "init_matrix", o_matrix, MW'(0));
        check(o_calc_cmd === 1'b0, "init_cmd", MW'(o_calc_cmd), MW'(0));
        check(o_busy === 1'b0, "init_busy", MW'(o_busy), MW'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Full frame with known leading words
        fill_random();
        words[0] = 32'h3fa00000;
        words[1] = 32'h430ffba6;
        send_frame(0, 0, 0, 0, fw);
        m = o_matrix;
        check(m[31:0] === 32'h3fa00000, "slice0", MW'(m[31:0]), MW'(32'h3fa00000));
        check(m[63:32] === 32'h430ffba6, "slice1", MW'(m[63:32]), MW'(32'h430ffba6));
        check(m[383:352] === words[11], "slice11", MW'(m[383:352]), MW'(words[11]));

        // Backpressure: next frame's first word held through CMD and a 20-cycle WAIT
        while (o_busy) @(negedge clk);
        force_delay = 20;
        fill_random();
        send_frame(0, 0, 0, 0, fw);
        fill_random();
        send_frame(0, 0, 0, 0, fw);
        check(fw == 21, "held_word_wait", MW'(fw), MW'(21));
        force_delay = 0;

        // Early last on word 5, then a clean frame
        fill_random();
        send_frame(1, 5, 0, 0, fw);
        fill_random();
        send_frame(0, 0, 0, 0, fw);

        // Missing last on word 12, then a clean frame
        fill_random();
        send_frame(2, 0, 0, 0, fw);
        fill_random();
        send_frame(0, 0, 0, 0, fw);

        // Reset mid-frame after word 7
        fill_random();
        send_frame(3, 7, 0, 0, fw);
        do_reset();

        // Reset while waiting on the solver
        force_delay = 20;
        fill_random();
        send_frame(0, 0, 0, 0, fw);
        repeat (5) @(negedge clk);
        check(o_busy === 1'b1, "busy_in_wait", MW'(o_busy), MW'(1));
        do_reset();
        force_delay = 0;

        // Clean frame, then the same frame with 1-of-3 strobe duty
        fill_random();
        send_frame(0, 0, 0, 0, fw);
        send_frame(0, 0, 2, 2, fw);

        // Randomized frame mix
        for (int f = 0; f < 40; f++) begin
            fill_random();
            kind = int'($urandom_range(0, 9));
            if (kind < 6) send_frame(0, 0, 0, 2, fw);
            else if (kind < 8) send_frame(1, int'($urandom_range(1, NE - 1)), 0, 2, fw);
            else send_frame(2, 0, 0, 2, fw);
        end

        repeat (40) @(negedge clk);
        check(exp_q.size() == 0, "scoreboard_drained", MW'(exp_q.size()), MW'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
